// File: rtl/sysarr_feeder_if.sv
// Load handshake and skewed lane outputs of the systolic-array feeder.
// The feeder takes the slave side; the upstream loader and lane consumer take the master side.
interface sysarr_feeder_if #(
  parameter int n = 15
);
  localparam int W = n + 1;

  logic             in_valid;
  logic             in_ready;
  logic [3*W-1:0]   in_a_row;
  logic [3*W-1:0]   in_b_col;
  logic [W-1:0]     a_out0;
  logic [W-1:0]     a_out1;
  logic [W-1:0]     a_out2;
  logic [W-1:0]     b_out0;
  logic [W-1:0]     b_out1;
  logic [W-1:0]     b_out2;
  logic             stream_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_a_row, in_b_col,
    input  in_ready, a_out0, a_out1, a_out2, b_out0, b_out1, b_out2,
    input  stream_valid, busy, done
  );

  modport slave (
    input  in_valid, in_a_row, in_b_col,
    output in_ready, a_out0, a_out1, a_out2, b_out0, b_out1, b_out2,
    output stream_valid, busy, done
  );
endinterface

// File: rtl/sysarr_feeder.sv
// Stores a 3x3 A (by rows) and B (by columns), then streams them diagonally skewed
// into the systolic array edges, waits for the array to drain and pulses done.
module sysarr_feeder #(
  parameter int n            = 15,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic           clock,
  input  logic           reset,
  sysarr_feeder_if.slave bus
);
  localparam int W  = n + 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t         state_reg, state_next;
  logic [1:0]     beat_reg, beat_next;
  logic [2:0]     t_reg, t_next;
  logic [DW-1:0]  drain_reg, drain_next;
  logic           ready_reg, ready_next;
  logic           stream_valid_reg, stream_valid_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;
  logic           accept;

  logic [W-1:0]   a_mem [3][3];
  logic [W-1:0]   b_mem [3][3];
  logic [W-1:0]   a_lane_reg [3];
  logic [W-1:0]   a_lane_next [3];
  logic [W-1:0]   b_lane_reg [3];
  logic [W-1:0]   b_lane_next [3];

  // Ready is registered, but masked by reset so nothing is offered while reset is held.
  assign bus.in_ready = ready_reg & ~reset;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= LOAD;
      beat_reg         <= 2'd0;
      t_reg            <= 3'd0;
      drain_reg        <= '0;
      ready_reg        <= 1'b1;
      stream_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        a_lane_reg[i] <= '0;
        b_lane_reg[i] <= '0;
      end
    end else begin
      state_reg        <= state_next;
      beat_reg         <= beat_next;
      t_reg            <= t_next;
      drain_reg        <= drain_next;
      ready_reg        <= ready_next;
      stream_valid_reg <= stream_valid_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      for (int i = 0; i < 3; i++) begin
        a_lane_reg[i] <= a_lane_next[i];
        b_lane_reg[i] <= b_lane_next[i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    t_next     = t_reg;
    drain_next = drain_reg;
    unique case (state_reg)
      LOAD: begin
        if (accept) begin
          beat_next = beat_reg + 2'd1;
          if (beat_reg == 2'd2) begin
            state_next = STREAM;
            t_next     = 3'd0;
          end
        end
      end
      STREAM: begin
        if (t_reg == 3'd4) begin
          state_next = DRAIN;
          drain_next = '0;
        end else begin
          t_next = t_reg + 3'd1;
        end
      end
      DRAIN: begin
        if (drain_reg == DW'(DRAIN_CYCLES - 1)) begin
          state_next = DONE;
        end else begin
          drain_next = drain_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = LOAD;
        beat_next  = 2'd0;
        t_next     = 3'd0;
      end
    endcase
    ready_next        = (state_next == LOAD);
    stream_valid_next = (state_next == STREAM);
    busy_next         = (state_next != LOAD);
    done_next         = (state_next == DONE);
  end

  // Row/column storage; persists until the next load overwrites it.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int j = 0; j < 3; j++) begin
        a_mem[beat_reg][j] <= bus.in_a_row[j*W +: W];
        b_mem[j][beat_reg] <= bus.in_b_col[j*W +: W];
      end
    end
  end

  // Lane k shows element (t-k) of its row/column; outside 0..2 it is padded with +0.0.
  // At t=0 only beat-0 data is read, so the beat-2 write landing on the same edge is harmless.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [2:0] idx;
    logic       hit;

    assign idx = t_next - 3'(gi);
    assign hit = (state_next == STREAM) && (t_next >= 3'(gi)) && (idx <= 3'd2);
    assign a_lane_next[gi] = hit ? a_mem[gi][idx[1:0]] : '0;
    assign b_lane_next[gi] = hit ? b_mem[idx[1:0]][gi] : '0;
  end

  assign bus.a_out0       = a_lane_reg[0];
  assign bus.a_out1       = a_lane_reg[1];
  assign bus.a_out2       = a_lane_reg[2];
  assign bus.b_out0       = b_lane_reg[0];
  assign bus.b_out1       = b_lane_reg[1];
  assign bus.b_out2       = b_lane_reg[2];
  assign bus.stream_valid = stream_valid_reg;
  assign bus.busy         = busy_reg;
  assign bus.done         = done_reg;
endmodule
